// File: rtl/nrisc_pipe_pkg.sv
// -----------------------------------------------------------------------------
// nrisc_pipe_pkg
// Shared definitions for the nRisc pipeline phase sequencer:
//   - phase indices (fetch, decode, execute, writeback)
//   - sequencer FSM state encoding
//   - default phase length
//   - helper that turns a phase index into a one-hot stage enable
// -----------------------------------------------------------------------------
package nrisc_pipe_pkg;

    localparam logic [1:0] PH_FETCH  = 2'd0;
    localparam logic [1:0] PH_DECODE = 2'd1;
    localparam logic [1:0] PH_EXEC   = 2'd2;
    localparam logic [1:0] PH_WB     = 2'd3;

    localparam int PHASE_LEN_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    // Map a phase index onto its stage-enable bit.
    function automatic logic [3:0] phase_onehot(input logic [1:0] ph);
        logic [3:0] oh_s;
        case (ph)
            PH_FETCH:  oh_s = 4'b0001;
            PH_DECODE: oh_s = 4'b0010;
            PH_EXEC:   oh_s = 4'b0100;
            PH_WB:     oh_s = 4'b1000;
            default:   oh_s = 4'b0000;
        endcase
        return oh_s;
    endfunction

endpackage

// File: rtl/nrisc_phase_counter.sv
// -----------------------------------------------------------------------------
// nrisc_phase_counter
// Intra-phase cycle counter. Counts 0..PHASE_LEN-1 and flags the terminal
// count so the sequencer knows when the current phase ends.
// Ports:
//   clock_i  core clock
//   reset_i  synchronous active-high reset (count -> 0)
//   en_i     increment enable
//   load_i   synchronous clear to 0 (wins over en_i)
//   tc_o     high while count == PHASE_LEN-1
// -----------------------------------------------------------------------------
module nrisc_phase_counter #(
    parameter int PHASE_LEN = 2,
    parameter int CNT_W     = 3
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic load_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(PHASE_LEN - 1);

    logic [CNT_W-1:0] count_q;

    // Counter register: reset and load clear, enable increments.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= {CNT_W{1'b0}};
        end else if (load_i) begin
            count_q <= {CNT_W{1'b0}};
        end else if (en_i) begin
            count_q <= count_q + CNT_W'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign tc_o = (count_q == TERM_CNT);

endmodule

// File: rtl/nrisc_phase_sequencer.sv
// -----------------------------------------------------------------------------
// nrisc_phase_sequencer
// Single-clock phase sequencer: drives one-hot stage enables for fetch,
// decode, execute and writeback, each lasting PHASE_LEN cycles, with
// run/halt (drain) and stall sequencing.
// Optional feature macro: STEP_MODE_EN (adds single-step request/ack).
// Ports:
//   clock_i        core clock
//   reset_i        synchronous active-high reset
//   run_i          level, sequence instruction cycles continuously
//   stall_i        level, freeze phase, counter and FSM
//   phase_en_o     one-hot stage enable (0 when idle)
//   phase_start_o  first cycle of each phase
//   cycle_done_o   writeback completes this cycle
//   busy_o         instruction cycle in progress
//   cycle_count_o  completed instruction cycles, wraps
//   step_req_i     single-step request (STEP_MODE_EN only)
//   step_ack_o     single-step completion pulse (STEP_MODE_EN only)
// -----------------------------------------------------------------------------
module nrisc_phase_sequencer
    import nrisc_pipe_pkg::*;
#(
    parameter int PHASE_LEN = PHASE_LEN_DEF,
    parameter int CNT_W     = 3
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        run_i,
    input  logic        stall_i,
    output logic [3:0]  phase_en_o,
    output logic        phase_start_o,
    output logic        cycle_done_o,
    output logic        busy_o,
    output logic [15:0] cycle_count_o
`ifdef STEP_MODE_EN
    ,
    input  logic        step_req_i,
    output logic        step_ack_o
`endif
);

    seq_state_e  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic        start_q, start_d;
    logic [15:0] cycle_count_q, cycle_count_d;
`ifdef STEP_MODE_EN
    logic        step_q, step_d;
`endif

    logic busy_s;
    logic tc_s;
    logic adv_s;
    logic done_s;
    logic go_s;
    logic cnt_en_s;

    assign busy_s   = (state_q != ST_IDLE);
    assign adv_s    = busy_s & ~stall_i & tc_s;
    assign done_s   = adv_s & (phase_q == PH_WB);
    assign cnt_en_s = busy_s & ~stall_i & ~tc_s;

    // The counter restarts both when a new run begins and on every phase advance.
    nrisc_phase_counter #(
        .PHASE_LEN (PHASE_LEN),
        .CNT_W     (CNT_W)
    ) u_counter (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .en_i    (cnt_en_s),
        .load_i  (go_s | adv_s),
        .tc_o    (tc_s)
    );

    // Next-state logic for FSM, phase, start flag, cycle count and step flag.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        go_s          = 1'b0;
`ifdef STEP_MODE_EN
        step_d        = step_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (stall_i) begin
                    state_d = ST_IDLE;
                end else if (run_i) begin
                    state_d = ST_RUN;
                    go_s    = 1'b1;
`ifdef STEP_MODE_EN
                end else if (step_req_i) begin
                    // A step is a drain that starts at fetch: one cycle, then idle.
                    state_d = ST_DRAIN;
                    go_s    = 1'b1;
                    step_d  = 1'b1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stall_i) begin
                    state_d = ST_RUN;
                end else if (!run_i) begin
                    // Halt requested on the final writeback cycle: nothing left to drain.
                    state_d = done_s ? ST_IDLE : ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (stall_i) begin
                    state_d = ST_DRAIN;
                end else if (run_i) begin
                    state_d = ST_RUN;
                end else if (done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_s) begin
            phase_d = PH_FETCH;
        end else if (adv_s) begin
            phase_d = phase_q + 2'd1;
        end else begin
            phase_d = phase_q;
        end

        // Start flag lives exactly one cycle, even when that cycle is stalled.
        start_d = go_s | adv_s;

        if (done_s) begin
            cycle_count_d = cycle_count_q + 16'd1;
        end else begin
            cycle_count_d = cycle_count_q;
        end

`ifdef STEP_MODE_EN
        if (done_s) begin
            step_d = 1'b0;
        end else begin
            step_d = step_d;
        end
`endif
    end

    // Sequencer state registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            phase_q       <= PH_FETCH;
            start_q       <= 1'b0;
            cycle_count_q <= 16'd0;
`ifdef STEP_MODE_EN
            step_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            start_q       <= start_d;
            cycle_count_q <= cycle_count_d;
`ifdef STEP_MODE_EN
            step_q        <= step_d;
`endif
        end
    end

    assign busy_o        = busy_s;
    assign phase_en_o    = busy_s ? phase_onehot(phase_q) : 4'b0000;
    assign phase_start_o = busy_s & start_q;
    assign cycle_done_o  = done_s;
    assign cycle_count_o = cycle_count_q;
`ifdef STEP_MODE_EN
    assign step_ack_o    = step_q & done_s;
`endif

endmodule

// File: tb/tb_nrisc_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nrisc_phase_sequencer
// Table-driven bench: dut0 uses PHASE_LEN=2, dut1 uses PHASE_LEN=1. Each table
// row gives the inputs for one cycle and the outputs expected in that cycle.
// -----------------------------------------------------------------------------
module tb_nrisc_phase_sequencer;

    typedef struct {
        int          id;
        logic        sel;
        logic        chk;
        logic        rst;
        logic        run;
        logic        stall;
        logic        step;
        logic [3:0]  pe;
        logic        ps;
        logic        cd;
        logic        bz;
        logic [15:0] cc;
        logic        ack;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, run0 = 1'b0, stall0 = 1'b0, step0 = 1'b0;
    logic        rst1 = 1'b1, run1 = 1'b0, stall1 = 1'b0, step1 = 1'b0;
    logic [3:0]  pe0, pe1;
    logic        ps0, ps1, cd0, cd1, bz0, bz1;
    logic [15:0] cc0, cc1;
    logic        ack0, ack1;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[$];
    vec_t sb[$];

    nrisc_phase_sequencer #(.PHASE_LEN(2), .CNT_W(3)) dut0 (
        .clock_i(clk), .reset_i(rst0), .run_i(run0), .stall_i(stall0),
        .phase_en_o(pe0), .phase_start_o(ps0), .cycle_done_o(cd0),
        .busy_o(bz0), .cycle_count_o(cc0)
`ifdef STEP_MODE_EN
        , .step_req_i(step0), .step_ack_o(ack0)
`endif
    );

    nrisc_phase_sequencer #(.PHASE_LEN(1), .CNT_W(3)) dut1 (
        .clock_i(clk), .reset_i(rst1), .run_i(run1), .stall_i(stall1),
        .phase_en_o(pe1), .phase_start_o(ps1), .cycle_done_o(cd1),
        .busy_o(bz1), .cycle_count_o(cc1)
`ifdef STEP_MODE_EN
        , .step_req_i(step1), .step_ack_o(ack1)
`endif
    );

`ifndef STEP_MODE_EN
    assign ack0 = 1'b0;
    assign ack1 = 1'b0;
`endif

    task automatic add(input logic sel, input logic chk, input logic rst,
                       input logic run, input logic stall, input logic step,
                       input logic [3:0] pe, input logic ps, input logic cd,
                       input logic bz, input logic [15:0] cc, input logic ack);
        vec_t v;
        v.id = vecs.size(); v.sel = sel; v.chk = chk; v.rst = rst; v.run = run;
        v.stall = stall; v.step = step; v.pe = pe; v.ps = ps; v.cd = cd;
        v.bz = bz; v.cc = cc; v.ack = ack;
        vecs.push_back(v);
    endtask

    // Two reset cycles; the second one checks the reset values.
    task automatic reset_pre(input logic sel);
        add(sel, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        add(sel, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    // Shorthand for non-step rows: sel, run, stall, pe, ps, cd, bz, cc.
    task automatic r(input logic sel, input logic run, input logic stall,
                     input logic [3:0] pe, input logic ps, input logic cd,
                     input logic bz, input logic [15:0] cc);
        add(sel, 1'b1, 1'b0, run, stall, 1'b0, pe, ps, cd, bz, cc, 1'b0);
    endtask

    task automatic chk(input string name, input int id,
                       input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %0h, expected %0h", name, id, got, exp);
        end
    endtask

    initial begin
        vec_t v;
        vec_t e;

        // Continuous run from cycle 0, then reset during the second decode start.
        reset_pre(1'b0);
        r(0, 1, 0, 4'b0000, 0, 0, 0, 16'd0);
        r(0, 1, 0, 4'b0001, 1, 0, 1, 16'd0);
        r(0, 1, 0, 4'b0001, 0, 0, 1, 16'd0);
        r(0, 1, 0, 4'b0010, 1, 0, 1, 16'd0);
        r(0, 1, 0, 4'b0010, 0, 0, 1, 16'd0);
        r(0, 1, 0, 4'b0100, 1, 0, 1, 16'd0);
        r(0, 1, 0, 4'b0100, 0, 0, 1, 16'd0);
        r(0, 1, 0, 4'b1000, 1, 0, 1, 16'd0);
        r(0, 1, 0, 4'b1000, 0, 1, 1, 16'd0);
        r(0, 1, 0, 4'b0001, 1, 0, 1, 16'd1);
        r(0, 1, 0, 4'b0001, 0, 0, 1, 16'd1);
        add(0, 1, 1, 1, 0, 0, 4'b0010, 1, 0, 1, 16'd1, 0);
        r(0, 1, 0, 4'b0000, 0, 0, 0, 16'd0);
        r(0, 1, 0, 4'b0001, 1, 0, 1, 16'd0);
        r(0, 1, 0, 4'b0001, 0, 0, 1, 16'd0);

        // Stalls: decode stretched, stall on a start cycle, stall on last writeback.
        reset_pre(1'b0);
        r(0, 1, 0, 4'b0000, 0, 0, 0, 16'd0);
        r(0, 1, 0, 4'b0001, 1, 0, 1, 16'd0);
        r(0, 1, 0, 4'b0001, 0, 0, 1, 16'd0);
        r(0, 1, 0, 4'b0010, 1, 0, 1, 16'd0);
        r(0, 1, 1, 4'b0010, 0, 0, 1, 16'd0);
        r(0, 1, 1, 4'b0010, 0, 0, 1, 16'd0);
        r(0, 1, 1, 4'b0010, 0, 0, 1, 16'd0);
        r(0, 1, 0, 4'b0010, 0, 0, 1, 16'd0);
        r(0, 1, 1, 4'b0100, 1, 0, 1, 16'd0);
        r(0, 1, 0, 4'b0100, 0, 0, 1, 16'd0);
        r(0, 1, 0, 4'b0100, 0, 0, 1, 16'd0);
        r(0, 1, 0, 4'b1000, 1, 0, 1, 16'd0);
        r(0, 1, 1, 4'b1000, 0, 0, 1, 16'd0);
        r(0, 1, 0, 4'b1000, 0, 1, 1, 16'd0);
        r(0, 1, 0, 4'b0001, 1, 0, 1, 16'd1);

        // Halt during decode drains to idle; restart; halt/resume without gap.
        reset_pre(1'b0);
        r(0, 1, 0, 4'b0000, 0, 0, 0, 16'd0);
        r(0, 1, 0, 4'b0001, 1, 0, 1, 16'd0);
        r(0, 1, 0, 4'b0001, 0, 0, 1, 16'd0);
        r(0, 0, 0, 4'b0010, 1, 0, 1, 16'd0);
        r(0, 0, 0, 4'b0010, 0, 0, 1, 16'd0);
        r(0, 0, 0, 4'b0100, 1, 0, 1, 16'd0);
        r(0, 0, 0, 4'b0100, 0, 0, 1, 16'd0);
        r(0, 0, 0, 4'b1000, 1, 0, 1, 16'd0);
        r(0, 0, 0, 4'b1000, 0, 1, 1, 16'd0);
        r(0, 0, 0, 4'b0000, 0, 0, 0, 16'd1);
        r(0, 0, 0, 4'b0000, 0, 0, 0, 16'd1);
        r(0, 1, 0, 4'b0000, 0, 0, 0, 16'd1);
        r(0, 1, 0, 4'b0001, 1, 0, 1, 16'd1);
        r(0, 0, 0, 4'b0001, 0, 0, 1, 16'd1);
        r(0, 1, 0, 4'b0010, 1, 0, 1, 16'd1);
        r(0, 1, 0, 4'b0010, 0, 0, 1, 16'd1);
        r(0, 1, 0, 4'b0100, 1, 0, 1, 16'd1);
        r(0, 1, 0, 4'b0100, 0, 0, 1, 16'd1);
        r(0, 1, 0, 4'b1000, 1, 0, 1, 16'd1);
        r(0, 1, 0, 4'b1000, 0, 1, 1, 16'd1);
        r(0, 1, 0, 4'b0001, 1, 0, 1, 16'd2);

        // PHASE_LEN=1: a new phase every unstalled cycle.
        reset_pre(1'b1);
        r(1, 1, 0, 4'b0000, 0, 0, 0, 16'd0);
        r(1, 1, 0, 4'b0001, 1, 0, 1, 16'd0);
        r(1, 1, 0, 4'b0010, 1, 0, 1, 16'd0);
        r(1, 1, 0, 4'b0100, 1, 0, 1, 16'd0);
        r(1, 1, 0, 4'b1000, 1, 1, 1, 16'd0);
        r(1, 1, 0, 4'b0001, 1, 0, 1, 16'd1);
        r(1, 1, 0, 4'b0010, 1, 0, 1, 16'd1);
        r(1, 1, 1, 4'b0100, 1, 0, 1, 16'd1);
        r(1, 1, 0, 4'b0100, 0, 0, 1, 16'd1);
        r(1, 1, 0, 4'b1000, 1, 1, 1, 16'd1);
        r(1, 1, 0, 4'b0001, 1, 0, 1, 16'd2);

`ifdef STEP_MODE_EN
        // Single step, second request mid-step ignored; then step converted to run.
        reset_pre(1'b0);
        add(0, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 16'd0, 0);
        add(0, 1, 0, 0, 0, 0, 4'b0001, 1, 0, 1, 16'd0, 0);
        add(0, 1, 0, 0, 0, 1, 4'b0001, 0, 0, 1, 16'd0, 0);
        add(0, 1, 0, 0, 0, 0, 4'b0010, 1, 0, 1, 16'd0, 0);
        add(0, 1, 0, 0, 0, 0, 4'b0010, 0, 0, 1, 16'd0, 0);
        add(0, 1, 0, 0, 0, 0, 4'b0100, 1, 0, 1, 16'd0, 0);
        add(0, 1, 0, 0, 0, 0, 4'b0100, 0, 0, 1, 16'd0, 0);
        add(0, 1, 0, 0, 0, 0, 4'b1000, 1, 0, 1, 16'd0, 0);
        add(0, 1, 0, 0, 0, 0, 4'b1000, 0, 1, 1, 16'd0, 1);
        add(0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 16'd1, 0);
        add(0, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 16'd1, 0);
        add(0, 1, 0, 1, 0, 0, 4'b0001, 1, 0, 1, 16'd1, 0);
        add(0, 1, 0, 1, 0, 0, 4'b0001, 0, 0, 1, 16'd1, 0);
        add(0, 1, 0, 1, 0, 0, 4'b0010, 1, 0, 1, 16'd1, 0);
        add(0, 1, 0, 1, 0, 0, 4'b0010, 0, 0, 1, 16'd1, 0);
        add(0, 1, 0, 1, 0, 0, 4'b0100, 1, 0, 1, 16'd1, 0);
        add(0, 1, 0, 1, 0, 0, 4'b0100, 0, 0, 1, 16'd1, 0);
        add(0, 1, 0, 1, 0, 0, 4'b1000, 1, 0, 1, 16'd1, 0);
        add(0, 1, 0, 1, 0, 0, 4'b1000, 0, 1, 1, 16'd1, 1);
        add(0, 1, 0, 1, 0, 0, 4'b0001, 1, 0, 1, 16'd2, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            v = vecs[i];
            if (v.sel) begin
                rst1 = v.rst; run1 = v.run; stall1 = v.stall; step1 = v.step;
                rst0 = 1'b1;  run0 = 1'b0;  stall0 = 1'b0;    step0 = 1'b0;
            end else begin
                rst0 = v.rst; run0 = v.run; stall0 = v.stall; step0 = v.step;
                rst1 = 1'b1;  run1 = 1'b0;  stall1 = 1'b0;    step1 = 1'b0;
            end
            if (v.chk) begin
                sb.push_back(v);
            end
            @(negedge clk);
            if (v.chk) begin
                e = sb.pop_front();
                chk("phase_en",    e.id, {12'd0, (e.sel ? pe1 : pe0)}, {12'd0, e.pe});
                chk("phase_start", e.id, {15'd0, (e.sel ? ps1 : ps0)}, {15'd0, e.ps});
                chk("cycle_done",  e.id, {15'd0, (e.sel ? cd1 : cd0)}, {15'd0, e.cd});
                chk("busy",        e.id, {15'd0, (e.sel ? bz1 : bz0)}, {15'd0, e.bz});
                chk("cycle_count", e.id, (e.sel ? cc1 : cc0), e.cc);
`ifdef STEP_MODE_EN
                chk("step_ack",    e.id, {15'd0, (e.sel ? ack1 : ack0)}, {15'd0, e.ack});
`endif
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
